// File: rtl/acoustics_pkg.sv
// Shared types and constants for the hydrophone acquisition path.
package acoustics_pkg;

    localparam int N_CH   = 4;
    localparam int DATA_W = 12;
    localparam int TS_W   = 32;

    typedef logic [DATA_W-1:0] sample_t;

    // One assembled frame. Channel k lands at bits [k*DATA_W +: DATA_W] of data,
    // which matches the in_data / out_data packing.
    typedef struct packed {
        logic [TS_W-1:0]         ts;
        logic [N_CH-1:0]         missing;
        sample_t [N_CH-1:0]      data;
    } frame_t;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } asm_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is visible on
// pop_data_o whenever empty_o is low. A push into a full FIFO is accepted
// only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign pop_ok     = pop_i & ~empty_o;
    assign push_ok    = push_i & (~full_o | pop_ok);
    assign pop_data_o = mem_q[rd_ptr_q];

    // Storage array: written on accepted pushes, never reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/adc_frame_assembler.sv
// Gathers one sample per hydrophone channel into an indexed frame, force-closes
// frames whose channels stall, and queues finished frames for the DSP/DMA stage.
module adc_frame_assembler
    import acoustics_pkg::*;
#(
    parameter int TIMEOUT    = 24,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic [TS_W-1:0]        out_ts,
    output logic [N_CH-1:0]        out_missing,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overflow,
    output logic                   dup_err,
    input  logic                   clear_err,
    output logic [15:0]            drop_count
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    asm_state_t          state_q, state_d;
    logic [N_CH-1:0]     mask_q, mask_d, mask_now;
    logic [TMR_W-1:0]    timer_q, timer_d, timer_now;
    sample_t [N_CH-1:0]  data_q, data_d, data_now;
    sample_t [N_CH-1:0]  in_sample;
    logic [TS_W-1:0]     idx_q, idx_d;
    logic                overflow_q, overflow_d;
    logic                dup_q, dup_d;
    logic [15:0]         drop_q, drop_d;
    logic                close, dup_evt, drop;
    frame_t              frame_w, head;
    logic                fifo_full, fifo_empty, pop;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_unpack
            assign in_sample[gi] = in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Frame collection FSM: capture strobes, detect duplicates, decide when to close.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        timer_d   = timer_q;
        data_d    = data_q;
        close     = 1'b0;
        dup_evt   = 1'b0;
        mask_now  = mask_q;
        data_now  = data_q;
        timer_now = timer_q + TMR_W'(1);
        case (state_q)
            IDLE: begin
                if (enable && (|in_valid)) begin
                    // Unstrobed channels start at zero so a missing channel reads 0.
                    for (int k = 0; k < N_CH; k++) begin
                        data_now[k] = in_valid[k] ? in_sample[k] : '0;
                    end
                    mask_now = in_valid;
                    if (&mask_now) begin
                        close = 1'b1;
                    end else begin
                        state_d = COLLECT;
                        mask_d  = mask_now;
                        data_d  = data_now;
                        timer_d = '0;
                    end
                end
            end
            COLLECT: begin
                if (!enable) begin
                    // Partial frame abandoned; index stays put.
                    state_d = IDLE;
                    mask_d  = '0;
                    timer_d = '0;
                end else begin
                    for (int k = 0; k < N_CH; k++) begin
                        if (in_valid[k] && !mask_q[k]) data_now[k] = in_sample[k];
                    end
                    dup_evt  = |(in_valid & mask_q);
                    mask_now = mask_q | in_valid;
                    // timer_now counts cycles since the opening cycle.
                    if ((&mask_now) || (timer_now == TMR_W'(TIMEOUT - 1))) begin
                        close   = 1'b1;
                        state_d = IDLE;
                        mask_d  = '0;
                        timer_d = '0;
                    end else begin
                        mask_d  = mask_now;
                        data_d  = data_now;
                        timer_d = timer_now;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                mask_d  = '0;
                timer_d = '0;
            end
        endcase
    end

    assign frame_w.ts      = idx_q;
    assign frame_w.missing = ~mask_now;
    assign frame_w.data    = data_now;

    assign pop  = ~fifo_empty & out_ready;
    assign drop = close & fifo_full & ~pop;

    // Frame index and sticky error flags; a set event beats clear_err.
    always_comb begin
        idx_d      = close ? idx_q + TS_W'(1) : idx_q;
        overflow_d = drop ? 1'b1 : (clear_err ? 1'b0 : overflow_q);
        dup_d      = dup_evt ? 1'b1 : (clear_err ? 1'b0 : dup_q);
        drop_d     = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            timer_q    <= '0;
            data_q     <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            dup_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            timer_q    <= timer_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            dup_q      <= dup_d;
            drop_q     <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(frame_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (close),
        .push_data_i (frame_w),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Head fields are zeroed when nothing is queued.
    assign out_valid   = ~fifo_empty;
    assign out_data    = out_valid ? head.data    : '0;
    assign out_ts      = out_valid ? head.ts      : '0;
    assign out_missing = out_valid ? head.missing : '0;
    assign overflow    = overflow_q;
    assign dup_err     = dup_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_adc_frame_assembler.sv
// Directed bench for adc_frame_assembler (N_CH=4, DATA_W=12, TIMEOUT=24, depth 16).
module tb_adc_frame_assembler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [47:0] in_data;
    logic [3:0]  in_valid;
    logic [47:0] out_data;
    logic [31:0] out_ts;
    logic [3:0]  out_missing;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        dup_err;
    logic        clear_err;
    logic [15:0] drop_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    adc_frame_assembler #(.TIMEOUT(24), .FIFO_DEPTH(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .out_data    (out_data),
        .out_ts      (out_ts),
        .out_missing (out_missing),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overflow    (overflow),
        .dup_err     (dup_err),
        .clear_err   (clear_err),
        .drop_count  (drop_count)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic strobe(input logic [3:0] v, input logic [47:0] d);
        in_valid = v;
        in_data  = d;
        cyc();
        in_valid = 4'b0000;
        in_data  = 48'h0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] check %-18s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b1; in_data = 48'h0; in_valid = 4'b0;
        out_ready = 1'b0; clear_err = 1'b0;
        idle(2);
        chk("rst_valid",   64'(out_valid),  64'h0);
        chk("rst_data",    64'(out_data),   64'h0);
        chk("rst_ts",      64'(out_ts),     64'h0);
        chk("rst_missing", 64'(out_missing), 64'h0);
        chk("rst_ovf",     64'(overflow),   64'h0);
        chk("rst_dup",     64'(dup_err),    64'h0);
        chk("rst_drops",   64'(drop_count), 64'h0);
        reset_n = 1'b1;
        cyc();

        // All four channels in one cycle: frame 0, visible next cycle.
        strobe(4'hF, 48'h444_333_222_111);
        chk("all4_valid",   64'(out_valid),   64'h1);
        chk("all4_data",    64'(out_data),    64'h444_333_222_111);
        chk("all4_ts",      64'(out_ts),      64'h0);
        chk("all4_missing", 64'(out_missing), 64'h0);
        pop_one();
        chk("all4_popped",  64'(out_valid),   64'h0);

        // Staggered strobes at cycles 0,3,5,9 with junk in unstrobed slots.
        strobe(4'b0001, 48'hFFF_FFF_FFF_A01);
        idle(2);
        strobe(4'b0010, 48'hFFF_FFF_B02_FFF);
        idle(1);
        strobe(4'b0100, 48'hFFF_C03_FFF_FFF);
        idle(3);
        chk("stag_open",    64'(out_valid),   64'h0);
        strobe(4'b1000, 48'hD04_FFF_FFF_FFF);
        chk("stag_valid",   64'(out_valid),   64'h1);
        chk("stag_data",    64'(out_data),    64'hD04_C03_B02_A01);
        chk("stag_ts",      64'(out_ts),      64'h1);
        chk("stag_missing", 64'(out_missing), 64'h0);
        pop_one();

        // Channel 2 silent: opens at t0, closes at t0+23, visible t0+24.
        strobe(4'b1011, 48'h0DD_EEE_0BB_0AA);
        idle(22);
        chk("tmo_not_yet",  64'(out_valid),   64'h0);
        cyc();
        chk("tmo_valid",    64'(out_valid),   64'h1);
        chk("tmo_ts",       64'(out_ts),      64'h2);
        chk("tmo_missing",  64'(out_missing), 64'h4);
        chk("tmo_data",     64'(out_data),    64'h0DD_000_0BB_0AA);
        pop_one();

        // Duplicate strobe on channel 1: first sample kept, dup_err set.
        strobe(4'b0010, 48'h000_000_123_000);
        strobe(4'b0010, 48'h000_000_456_000);
        chk("dup_flag",     64'(dup_err),     64'h1);
        strobe(4'b1101, 48'h004_003_FFF_001);
        chk("dup_data",     64'(out_data),    64'h004_003_123_001);
        chk("dup_ts",       64'(out_ts),      64'h3);
        clear_err = 1'b1;
        out_ready = 1'b1;
        cyc();
        clear_err = 1'b0;
        out_ready = 1'b0;
        chk("dup_cleared",  64'(dup_err),     64'h0);

        // enable low mid-frame discards it without consuming an index.
        strobe(4'b0001, 48'h000_000_000_555);
        enable = 1'b0;
        strobe(4'b1110, 48'h999_999_999_000);
        enable = 1'b1;
        chk("dis_nowrite",  64'(out_valid),   64'h0);
        strobe(4'hF, 48'h00D_00C_00B_00A);
        chk("dis_ts",       64'(out_ts),      64'h4);
        chk("dis_data",     64'(out_data),    64'h00D_00C_00B_00A);
        pop_one();

        // 17 frames with no consumer: ts 5..20 stored, ts 21 dropped.
        for (int i = 0; i < 16; i++) strobe(4'hF, 48'hFED_CBA_987_654);
        chk("fill_noovf",   64'(overflow),    64'h0);
        strobe(4'hF, 48'h111_111_111_111);
        chk("ovf_flag",     64'(overflow),    64'h1);
        chk("ovf_drops",    64'(drop_count),  64'h1);
        chk("ovf_head_ts",  64'(out_ts),      64'h5);
        chk("ovf_head_dat", 64'(out_data),    64'hFED_CBA_987_654);

        // Full FIFO: pop and close in the same cycle, frame ts 22 is kept.
        in_valid  = 4'hF;
        in_data   = 48'h222_222_222_222;
        out_ready = 1'b1;
        cyc();
        in_valid  = 4'b0;
        chk("fullpp_drops", 64'(drop_count),  64'h1);
        for (int i = 0; i < 16; i++) begin
            chk("drain_valid", 64'(out_valid), 64'h1);
            chk("drain_ts",    64'(out_ts),    (i < 15) ? 64'(6 + i) : 64'd22);
            cyc();
        end
        chk("drain_empty",  64'(out_valid),   64'h0);
        out_ready = 1'b0;
        clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;
        chk("ovf_cleared",  64'(overflow),    64'h0);
        chk("drops_kept",   64'(drop_count),  64'h1);

        // Reset in the middle of a frame.
        strobe(4'hF, 48'h333_333_333_333);
        strobe(4'b0001, 48'h000_000_000_777);
        chk("pre_rst_valid", 64'(out_valid),  64'h1);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("mrst_valid",   64'(out_valid),   64'h0);
        chk("mrst_drops",   64'(drop_count),  64'h0);
        strobe(4'b1110, 48'h888_666_555_000);
        chk("mrst_open",    64'(out_valid),   64'h0);
        strobe(4'b0001, 48'h000_000_000_999);
        chk("mrst_ts",      64'(out_ts),      64'h0);
        chk("mrst_data",    64'(out_data),    64'h888_666_555_999);
        chk("mrst_missing", 64'(out_missing), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
